// File: rtl/uart_if_pkg.sv
// -----------------------------------------------------------------------------
// uart_if_pkg
// Shared definitions for the UART-to-ALU bridge:
//   - default byte / opcode widths
//   - one-hot FSM state encoding
//   - small helper to classify states that drop incoming bytes
// Optional feature macro used by the bridge: UART_IF_TIMEOUT_EN
// -----------------------------------------------------------------------------
package uart_if_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int OP_WIDTH_DEF   = 6;

  // One-hot state encoding; any other pattern is treated as illegal.
  typedef enum logic [5:0] {
    ST_WAIT_A   = 6'b000001,
    ST_WAIT_B   = 6'b000010,
    ST_WAIT_OP  = 6'b000100,
    ST_COMPUTE  = 6'b001000,
    ST_SEND     = 6'b010000,
    ST_WAIT_TX  = 6'b100000
  } state_e;

  // States in which a freshly received byte cannot be accepted.
  function automatic logic state_drops_bytes(input state_e s);
    logic drop;
    case (s)
      ST_COMPUTE: drop = 1'b1;
      ST_SEND:    drop = 1'b1;
      ST_WAIT_TX: drop = 1'b1;
      default:    drop = 1'b0;
    endcase
    return drop;
  endfunction

  // States in which the inter-byte timeout runs.
  function automatic logic state_mid_frame(input state_e s);
    logic mid;
    case (s)
      ST_WAIT_B:  mid = 1'b1;
      ST_WAIT_OP: mid = 1'b1;
      default:    mid = 1'b0;
    endcase
    return mid;
  endfunction

endpackage : uart_if_pkg

// File: rtl/uart_if_timeout.sv
// -----------------------------------------------------------------------------
// uart_if_timeout
// Inter-byte timeout counter. Counts enabled cycles and flags expiry when the
// count reaches CYCLES-1; the count saturates there until cleared.
// Ports:
//   i_clock   - clock, rising edge
//   i_reset   - asynchronous active-low reset
//   i_clear   - synchronous clear of the count (has priority over enable)
//   i_enable  - count this cycle
//   o_expired - count has reached CYCLES-1 while enabled
// -----------------------------------------------------------------------------
module uart_if_timeout
  import uart_if_pkg::*;
#(
  parameter int CYCLES = 65535
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: clear wins, otherwise increment up to the saturation point.
  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_enable && (count_q != LAST)) begin
      count_d = count_q + ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_expired = i_enable && (count_q == LAST);

endmodule : uart_if_timeout

// File: rtl/uart_alu_if.sv
// -----------------------------------------------------------------------------
// uart_alu_if
// Collects three UART bytes (operand A, operand B, opcode), presents them to
// an external combinational ALU, then hands the result byte to the UART
// transmitter and waits for it to be sent.
// Ports:
//   i_clock       - single clock, rising edge
//   i_reset       - asynchronous active-low reset
//   i_rx_done     - receiver byte-complete strobe (edge-detected)
//   i_rx_data     - received byte, valid while i_rx_done is high
//   i_alu_result  - combinational ALU result
//   i_tx_done     - transmitter byte-sent strobe
//   o_alu_a/b     - registered operands
//   o_alu_op      - registered opcode (low OP_WIDTH bits of the opcode byte)
//   o_tx_start    - one-cycle transmit request
//   o_tx_data     - registered result byte
//   o_busy        - high whenever the FSM is not in WAIT_A
//   o_overrun     - sticky: a byte arrived while a result was being handled
// Optional feature: define UART_IF_TIMEOUT_EN to abandon a partial frame
// after TIMEOUT_CYCLES idle cycles in WAIT_B / WAIT_OP.
// -----------------------------------------------------------------------------
module uart_alu_if
  import uart_if_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int OP_WIDTH       = OP_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_rx_done,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  input  logic                  i_tx_done,
  output logic [DATA_WIDTH-1:0] o_alu_a,
  output logic [DATA_WIDTH-1:0] o_alu_b,
  output logic [OP_WIDTH-1:0]   o_alu_op,
  output logic                  o_tx_start,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic                  o_busy,
  output logic                  o_overrun
);

  state_e                state_q,   state_d;
  logic                  rx_prev_q;
  logic [DATA_WIDTH-1:0] alu_a_q,   alu_a_d;
  logic [DATA_WIDTH-1:0] alu_b_q,   alu_b_d;
  logic [OP_WIDTH-1:0]   alu_op_q,  alu_op_d;
  logic                  tx_start_q, tx_start_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  busy_q,    busy_d;
  logic                  overrun_q, overrun_d;

  logic byte_evt_s;
  logic drop_s;
  logic timeout_expired_s;

  // A strobe held high for several cycles still counts as one byte.
  assign byte_evt_s = i_rx_done && !rx_prev_q;
  assign drop_s     = byte_evt_s && state_drops_bytes(state_q);

`ifdef UART_IF_TIMEOUT_EN
  logic to_enable_s;
  logic to_clear_s;

  // Count only mid-frame; any byte restarts the idle interval.
  assign to_enable_s = state_mid_frame(state_q);
  assign to_clear_s  = byte_evt_s || !to_enable_s;

  uart_if_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_clear   (to_clear_s),
    .i_enable  (to_enable_s),
    .o_expired (timeout_expired_s)
  );
`else
  assign timeout_expired_s = 1'b0;
`endif

  // Next-state and next-output logic for the frame FSM.
  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    overrun_d  = overrun_q || drop_s;

    case (state_q)
      ST_WAIT_A: begin
        if (byte_evt_s) begin
          alu_a_d = i_rx_data;
          state_d = ST_WAIT_B;
        end else begin
          state_d = ST_WAIT_A;
        end
      end
      ST_WAIT_B: begin
        if (byte_evt_s) begin
          alu_b_d = i_rx_data;
          state_d = ST_WAIT_OP;
        end else if (timeout_expired_s) begin
          state_d = ST_WAIT_A;
        end else begin
          state_d = ST_WAIT_B;
        end
      end
      ST_WAIT_OP: begin
        if (byte_evt_s) begin
          // Upper opcode-byte bits are deliberately discarded.
          alu_op_d = i_rx_data[OP_WIDTH-1:0];
          state_d  = ST_COMPUTE;
        end else if (timeout_expired_s) begin
          state_d = ST_WAIT_A;
        end else begin
          state_d = ST_WAIT_OP;
        end
      end
      ST_COMPUTE: begin
        // Operands have been stable for a full cycle; the ALU has settled.
        // Raising tx_start here makes it a registered pulse during SEND.
        tx_data_d  = i_alu_result;
        tx_start_d = 1'b1;
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        state_d = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (i_tx_done) begin
          state_d = ST_WAIT_A;
        end else begin
          state_d = ST_WAIT_TX;
        end
      end
      default: begin
        // Illegal (non one-hot) encoding recovers to idle.
        state_d = ST_WAIT_A;
      end
    endcase

    busy_d = (state_d != ST_WAIT_A);
  end

  // State, edge-detect and output registers.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_WAIT_A;
      rx_prev_q  <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_prev_q  <= i_rx_done;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  assign o_alu_a    = alu_a_q;
  assign o_alu_b    = alu_b_q;
  assign o_alu_op   = alu_op_q;
  assign o_tx_start = tx_start_q;
  assign o_tx_data  = tx_data_q;
  assign o_busy     = busy_q;
  assign o_overrun  = overrun_q;

endmodule : uart_alu_if

// File: tb/tb_uart_alu_if.sv
// -----------------------------------------------------------------------------
// tb_uart_alu_if
// Directed self-checking bench for uart_alu_if. The bench ALU adds A+B for
// opcode 0x20 and XORs A^B for any other opcode.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_alu_if;

  logic       clk;
  logic       rst_n;
  logic       rx_done;
  logic [7:0] rx_data;
  logic [7:0] alu_result;
  logic       tx_done;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [5:0] alu_op;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       busy;
  logic       overrun;

  int n_tests;
  int n_fail;
  int tx_start_cnt;
  int cnt_before;

  uart_alu_if #(
    .DATA_WIDTH     (8),
    .OP_WIDTH       (6),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .i_clock      (clk),
    .i_reset      (rst_n),
    .i_rx_done    (rx_done),
    .i_rx_data    (rx_data),
    .i_alu_result (alu_result),
    .i_tx_done    (tx_done),
    .o_alu_a      (alu_a),
    .o_alu_b      (alu_b),
    .o_alu_op     (alu_op),
    .o_tx_start   (tx_start),
    .o_tx_data    (tx_data),
    .o_busy       (busy),
    .o_overrun    (overrun)
  );

  // Bench ALU.
  assign alu_result = (alu_op == 6'h20) ? (alu_a + alu_b) : (alu_a ^ alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count transmit requests, sampled away from the active edge.
  always @(negedge clk) begin
    if (tx_start) tx_start_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_done = 1'b1;
    rx_data = b;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
  endtask

  task automatic tx_ack();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    tx_start_cnt = 0;
    rx_done = 1'b0;
    rx_data = 8'h00;
    tx_done = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #3;
    // Asynchronous reset, before any clock edge.
    check("rst_busy",     {31'd0, busy},     32'd0);
    check("rst_a",        {24'd0, alu_a},    32'd0);
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_overrun",  {31'd0, overrun},  32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Frame 1: 05 03 20 -> 08, tx_start two cycles after opcode event.
    send_byte(8'h05);
    check("f1_a",    {24'd0, alu_a}, 32'h05);
    check("f1_busy", {31'd0, busy},  32'd1);
    send_byte(8'h03);
    check("f1_b", {24'd0, alu_b}, 32'h03);
    send_byte(8'h20);
    check("f1_op",         {26'd0, alu_op},   32'h20);
    check("f1_start_lat1", {31'd0, tx_start}, 32'd0);
    tick();
    check("f1_start_lat2", {31'd0, tx_start}, 32'd1);
    check("f1_tx_data",    {24'd0, tx_data},  32'h08);
    tick();
    check("f1_start_pulse", {31'd0, tx_start}, 32'd0);
    check("f1_waittx_busy", {31'd0, busy},     32'd1);
    tx_ack();
    check("f1_done_busy", {31'd0, busy}, 32'd0);
    check("f1_start_cnt", tx_start_cnt,  32'd1);

    // Frame 2: opcode byte E2 keeps only low 6 bits -> 0x22, XOR result.
    send_byte(8'h10);
    send_byte(8'h07);
    send_byte(8'hE2);
    check("f2_op", {26'd0, alu_op}, 32'h22);
    tick();
    check("f2_tx_data", {24'd0, tx_data}, 32'h17);
    tick();
    tx_ack();

    // Frame 3: rx_done held 3 cycles on byte A counts once.
    @(posedge clk);
    #1;
    rx_done = 1'b1;
    rx_data = 8'h0A;
    tick();
    tick();
    tick();
    rx_done = 1'b0;
    check("hold_a",    {24'd0, alu_a}, 32'h0A);
    check("hold_busy", {31'd0, busy},  32'd1);
    send_byte(8'h0B);
    check("hold_b",       {24'd0, alu_b},  32'h0B);
    check("hold_op_kept", {26'd0, alu_op}, 32'h22);
    send_byte(8'h20);
    tick();
    check("f3_tx_data", {24'd0, tx_data}, 32'h15);
    tick();

    // Byte during WAIT_TX is dropped and flags overrun.
    check("pre_overrun", {31'd0, overrun}, 32'd0);
    send_byte(8'h99);
    check("ovr_flag", {31'd0, overrun}, 32'd1);
    check("ovr_a",    {24'd0, alu_a},   32'h0A);
    check("ovr_busy", {31'd0, busy},    32'd1);
    tx_ack();
    check("ovr_idle", {31'd0, busy}, 32'd0);

    // Frame 4 after overrun proceeds normally; overrun stays sticky.
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h20);
    check("f4_a", {24'd0, alu_a}, 32'h01);
    check("f4_b", {24'd0, alu_b}, 32'h02);
    tick();
    check("f4_tx_data", {24'd0, tx_data}, 32'h03);
    tick();
    tx_ack();
    check("f4_overrun",   {31'd0, overrun}, 32'd1);
    check("f4_start_cnt", tx_start_cnt,     32'd4);

    // Reset after byte B abandons the frame.
    send_byte(8'h33);
    send_byte(8'h44);
    cnt_before = tx_start_cnt;
    rst_n = 1'b0;
    #2;
    check("mid_rst_busy",    {31'd0, busy},    32'd0);
    check("mid_rst_a",       {24'd0, alu_a},   32'd0);
    check("mid_rst_b",       {24'd0, alu_b},   32'd0);
    check("mid_rst_op",      {26'd0, alu_op},  32'd0);
    check("mid_rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("mid_rst_overrun", {31'd0, overrun}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("mid_rst_no_start", tx_start_cnt, cnt_before);
    check("mid_rst_idle",     {31'd0, busy}, 32'd0);
    send_byte(8'h55);
    check("post_rst_a", {24'd0, alu_a}, 32'h55);
    check("post_rst_b", {24'd0, alu_b}, 32'd0);

`ifdef UART_IF_TIMEOUT_EN
    // Now in WAIT_B: 16 idle cycles return to WAIT_A, not 15.
    for (int i = 0; i < 15; i++) tick();
    check("to_not_yet", {31'd0, busy}, 32'd1);
    tick();
    check("to_expired", {31'd0, busy}, 32'd0);
    send_byte(8'h66);
    check("to_next_is_a", {24'd0, alu_a}, 32'h66);
    check("to_b_kept",    {24'd0, alu_b}, 32'd0);
`else
    // No timeout: WAIT_B holds indefinitely.
    for (int i = 0; i < 40; i++) tick();
    check("nto_still_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h77);
    check("nto_b",        {24'd0, alu_b}, 32'h77);
    check("nto_a_kept",   {24'd0, alu_a}, 32'h55);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_uart_alu_if
